// File: rtl/dut.sv
// Registered pass-through: STAGES cascaded WIDTH-bit flops with asynchronous reset.
// The reset input is named rstn but is active-high.
module dut #(
    parameter int unsigned            WIDTH       = 1,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
    parameter int                     STAGES      = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             rstn,
    input  logic             clk,
    output logic [WIDTH-1:0] q
);

    // Out-of-range stage counts must not elaborate.
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("dut: STAGES must be in the range 1..8");
    end

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_dut.sv
// Directed bench: default single flop plus an 8-bit, 3-stage, A5-reset instance.
module tb_dut;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [0:0] d_a;
    logic [0:0] q_a;
    logic [7:0] d_b;
    logic [7:0] q_b;

    int total;
    int bad;

    dut u_dut_a (
        .d    (d_a),
        .rstn (rst_a),
        .clk  (clk),
        .q    (q_a)
    );

    dut #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .STAGES      (3)
    ) u_dut_b (
        .d    (d_b),
        .rstn (rst_b),
        .clk  (clk),
        .q    (q_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [8:0] seq;
    logic       prev;

    initial begin
        total = 0;
        bad   = 0;
        seq   = 9'b000100110; // bit i is the value applied before edge i: 0,1,1,0,0,1,0,0,0
        rst_a = 1'b1;
        rst_b = 1'b1;
        d_a   = 1'b0;
        d_b   = 8'h00;
        #1;
        chk("reset_a_async", {7'd0, q_a}, 8'h00);
        chk("reset_b_async", q_b, 8'hA5);

        // Reset held across edges while d toggles.
        for (int i = 0; i < 3; i++) begin
            d_a = ~d_a;
            d_b = d_b + 8'h11;
            tick();
            chk("reset_a_held", {7'd0, q_a}, 8'h00);
            chk("reset_b_held", q_b, 8'hA5);
        end

        // Release reset mid-cycle.
        #2;
        rst_a = 1'b0;
        d_a   = 1'b0;
        #1;
        chk("release_a", {7'd0, q_a}, 8'h00);

        // Directed sequence: q is d delayed by one edge, never combinational.
        prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d_a = seq[i];
            #1;
            chk("seq_pre_edge", {7'd0, q_a}, {7'd0, prev});
            tick();
            chk("seq_post_edge", {7'd0, q_a}, {7'd0, seq[i]});
            prev = seq[i];
        end

        // Asynchronous reset pulse between edges.
        d_a = 1'b1;
        tick();
        chk("mid_q_one", {7'd0, q_a}, 8'h01);
        #2;
        rst_a = 1'b1;
        #1;
        chk("mid_async_clear", {7'd0, q_a}, 8'h00);
        rst_a = 1'b0;
        #1;
        chk("mid_still_clear", {7'd0, q_a}, 8'h00);
        tick();
        chk("mid_restore", {7'd0, q_a}, 8'h01);

        // Reset asserted in the same time step as the clock edge, d = 1.
        @(posedge clk);
        rst_a = 1'b1;
        #1;
        chk("coincident_reset", {7'd0, q_a}, 8'h00);
        #3;
        rst_a = 1'b0;

        // Hold d = 1 for ten edges, checking at each edge and mid-cycle.
        d_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_edge", {7'd0, q_a}, 8'h01);
            #4;
            chk("hold_mid", {7'd0, q_a}, 8'h01);
        end

        // Wide, 3-stage instance.
        #1;
        rst_b = 1'b0;
        d_b   = 8'h01;
        #1;
        chk("b_release", q_b, 8'hA5);
        tick();
        chk("b_edge1", q_b, 8'hA5);
        d_b = 8'h02;
        tick();
        chk("b_edge2", q_b, 8'hA5);
        d_b = 8'h03;
        tick();
        chk("b_edge3", q_b, 8'h01);
        d_b = 8'h00;
        tick();
        chk("b_edge4", q_b, 8'h02);
        tick();
        chk("b_edge5", q_b, 8'h03);
        tick();
        chk("b_edge6", q_b, 8'h00);

        // Mid-stream reset on the wide instance clears every stage.
        d_b = 8'h5C;
        tick();
        tick();
        #2;
        rst_b = 1'b1;
        #1;
        chk("b_async_clear", q_b, 8'hA5);
        rst_b = 1'b0;
        tick();
        chk("b_refill1", q_b, 8'hA5);
        tick();
        chk("b_refill2", q_b, 8'hA5);
        tick();
        chk("b_refill3", q_b, 8'h5C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
